// File: rtl/aes_core_arbiter_if.sv
// Requester-side and AES-core-side signal bundle for aes_core_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic
// (requester register sets plus the AES decryption core).
interface aes_core_arbiter_if;
  // requester side
  logic [1:0]   REQ_START;
  logic [127:0] REQ_KEY0;
  logic [127:0] REQ_MSG0;
  logic [127:0] REQ_KEY1;
  logic [127:0] REQ_MSG1;
  logic [1:0]   GRANT;
  logic [1:0]   REQ_DONE;
  logic [127:0] REQ_DEC;
  logic         ERR;
  // core side
  logic         AES_START;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic         AES_RESET;
  logic         AES_DONE;
  logic [127:0] AES_MSG_DEC;

  modport slave (
    input  REQ_START, REQ_KEY0, REQ_MSG0, REQ_KEY1, REQ_MSG1,
    input  AES_DONE, AES_MSG_DEC,
    output GRANT, REQ_DONE, REQ_DEC, ERR,
    output AES_START, AES_KEY, AES_MSG_ENC, AES_RESET
  );

  modport master (
    output REQ_START, REQ_KEY0, REQ_MSG0, REQ_KEY1, REQ_MSG1,
    output AES_DONE, AES_MSG_DEC,
    input  GRANT, REQ_DONE, REQ_DEC, ERR,
    input  AES_START, AES_KEY, AES_MSG_ENC, AES_RESET
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES decryption core between two requesters.
// Latency: grant and AES_START one cycle after the request is sampled; all outputs registered.
// Backpressure: requests wait while the core is owned; result held until the owner drops REQ_START.
// Optional watchdog abort on a hung core is enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              CLK,
  input logic              RESET,
  aes_core_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   grant_q, grant_d;
  logic         last_q, last_d;        // 1: requester 1 was served last
  logic         aes_start_q, aes_start_d;
  logic [127:0] aes_key_q, aes_key_d;
  logic [127:0] aes_msg_q, aes_msg_d;
  logic [1:0]   req_done_q, req_done_d;
  logic [127:0] req_dec_q, req_dec_d;
  logic         pick_one;              // requester 1 wins this arbitration
  logic         owner_req;             // granted requester still holds its request

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          aes_reset_q, aes_reset_d;
`endif

  assign owner_req = |(bus.REQ_START & grant_q);

  // Next-state and next-output computation for the arbitration FSM
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    aes_start_d = aes_start_q;
    aes_key_d   = aes_key_q;
    aes_msg_d   = aes_msg_q;
    req_done_d  = req_done_q;
    req_dec_d   = req_dec_q;
    pick_one    = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
    aes_reset_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.REQ_START) begin
          // a tie goes to whoever was not served last
          pick_one    = (bus.REQ_START == 2'b10) ||
                        ((bus.REQ_START == 2'b11) && !last_q);
          grant_d     = pick_one ? 2'b10 : 2'b01;
          aes_key_d   = pick_one ? bus.REQ_KEY1 : bus.REQ_KEY0;
          aes_msg_d   = pick_one ? bus.REQ_MSG1 : bus.REQ_MSG0;
          aes_start_d = 1'b1;
          state_d     = BUSY;
`ifdef AES_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY: begin
        // a done arriving on the timeout cycle still counts as a normal result
        if (bus.AES_DONE) begin
          req_dec_d   = bus.AES_MSG_DEC;
          aes_start_d = 1'b0;
          state_d     = RELEASE;
        end
`ifdef AES_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          req_dec_d   = '0;
          aes_start_d = 1'b0;
          aes_reset_d = 1'b1;
          err_d       = 1'b1;
          state_d     = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RELEASE: begin
        // wait for the core to fall back to Halted before handing out the result
        if (!bus.AES_DONE) begin
          if (owner_req) begin
            req_done_d = grant_q;
            state_d    = RESPOND;
          end else begin
            grant_d = 2'b00;
            state_d = IDLE;
`ifdef AES_ARB_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end
        end
      end
      RESPOND: begin
        if (!owner_req) begin
          req_done_d = 2'b00;
          grant_d    = 2'b00;
          last_d     = grant_q[1];
          state_d    = IDLE;
`ifdef AES_ARB_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      aes_start_q <= 1'b0;
      aes_key_q   <= '0;
      aes_msg_q   <= '0;
      req_done_q  <= 2'b00;
      req_dec_q   <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
      aes_reset_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      aes_start_q <= aes_start_d;
      aes_key_q   <= aes_key_d;
      aes_msg_q   <= aes_msg_d;
      req_done_q  <= req_done_d;
      req_dec_q   <= req_dec_d;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      aes_reset_q <= aes_reset_d;
`endif
    end
  end

  assign bus.GRANT       = grant_q;
  assign bus.REQ_DONE    = req_done_q;
  assign bus.REQ_DEC     = req_dec_q;
  assign bus.AES_START   = aes_start_q;
  assign bus.AES_KEY     = aes_key_q;
  assign bus.AES_MSG_ENC = aes_msg_q;
`ifdef AES_ARB_TIMEOUT_EN
  assign bus.ERR         = err_q;
  assign bus.AES_RESET   = aes_reset_q;
`else
  assign bus.ERR         = 1'b0;
  assign bus.AES_RESET   = 1'b0;
`endif

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES decryption core between two requesters, e.g. two software-visible register sets.
- On each grant it latches the winner's key and ciphertext, then drives the core's level-held start/done handshake.
- It captures the plaintext and returns it to the winner. Arbitration is round-robin.
- Sits between the requester-facing interface logic and the AES decryption core.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUSY before abort. Used only with the optional feature.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- REQ_START  in  2  per-requester level request; held high until that requester's REQ_DONE is seen
- REQ_KEY0  in  128  requester 0 key
- REQ_MSG0  in  128  requester 0 ciphertext
- REQ_KEY1  in  128  requester 1 key
- REQ_MSG1  in  128  requester 1 ciphertext
- GRANT  out  2  one-hot owner of the core; 0 when idle
- REQ_DONE  out  2  one-hot; result valid for that requester
- REQ_DEC  out  128  result register; meaningful only while REQ_DONE is nonzero
- ERR  out  1  timeout abort flag, qualifies REQ_DONE
- AES_START  out  1  to core, level
- AES_KEY  out  128  to core
- AES_MSG_ENC  out  128  to core
- AES_RESET  out  1  core abort pulse, ORed with RESET at the core
- AES_DONE  in  1  from core; high while core is in Done and AES_START is high
- AES_MSG_DEC  in  128  from core

Behaviour:
- Reset values: all outputs 0, state IDLE, last-served pointer = 1 (requester 0 wins first tie), timeout counter 0. RESET mid-operation aborts immediately with no result; the core shares RESET.
- All outputs are registered.
- IDLE:
  - If any REQ_START bit is set, choose the winner. On a single request the requester wins. On both, the requester not last served wins.
  - Latch the winner's key/msg into AES_KEY/AES_MSG_ENC, set GRANT, go BUSY.
  - AES_START rises the cycle after the request is sampled.
- BUSY:
  - AES_START=1.
  - On AES_DONE=1: capture AES_MSG_DEC into REQ_DEC, go RELEASE.
- RELEASE:
  - AES_START=0.
  - Stay until AES_DONE=0 (core returned to Halted).
  - Then go RESPOND if the granted requester's REQ_START is still high. Otherwise go IDLE and discard the result.
- RESPOND:
  - REQ_DONE[g]=1, REQ_DEC held.
  - When REQ_START[g]=0, clear REQ_DONE and GRANT, update the last-served pointer to g, go IDLE.
- Withdrawal: if the granted requester drops REQ_START during BUSY, the operation still completes. The core is never aborted by withdrawal.
- Non-granted requests: wait with no side effect. REQ_KEY/REQ_MSG of either requester are ignored except at the grant cycle.
- Back-to-back: minimum one IDLE cycle between operations. A requester re-asserting REQ_START while the other is pending loses the tie.
- AES_KEY/AES_MSG_ENC are stable from grant until return to IDLE.
- GRANT is one-hot or zero at all times. REQ_DONE is never set for a non-granted requester.

Optional Feature:
- Macro AES_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in BUSY. When it reaches TIMEOUT_CYCLES with no AES_DONE, AES_START is dropped and AES_RESET pulses high for exactly one cycle.
  - REQ_DEC is cleared to 0 and ERR is set. The block then goes to RELEASE.
  - RESPOND asserts REQ_DONE with ERR=1.
  - ERR clears together with REQ_DONE.
  - AES_DONE arriving on the same cycle as the timeout wins: normal capture, no abort.
- When undefined: no counter, AES_RESET and ERR are tied 0, and BUSY waits indefinitely.

Test Plan:
- Single request:
  - Stimulus: REQ_START=01, key 000102..0F, msg M; model core raises AES_DONE 90 cycles after AES_START with result P.
  - Response: GRANT=01 and AES_START=1 one cycle after the request; REQ_DONE=01 with REQ_DEC=P after AES_DONE drops; GRANT=00 after REQ_START falls.
- Simultaneous:
  - Stimulus: REQ_START=11 out of reset.
  - Response: requester 0 served first, then requester 1. Each requester's own key appears on AES_KEY during its grant. A second 11 tie after that serves requester 0 again, since requester 1 was last served.
- Fairness:
  - Stimulus: requester 0 re-requests immediately after each completion while requester 1 holds its request.
  - Response: grants alternate 01,10,01,10.
- Withdrawal:
  - Stimulus: requester 1 drops REQ_START mid-BUSY.
  - Response: core runs to AES_DONE, AES_START drops, REQ_DONE stays 00, return to IDLE, and a pending requester 0 is granted next.
- Reset mid-BUSY:
  - Stimulus: pulse RESET 1 cycle.
  - Response: next cycle all outputs are 0, state IDLE, and requester 0 has priority.
- Timeout (AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20):
  - Stimulus: model core never asserts AES_DONE.
  - Response: AES_RESET is a one-cycle pulse 20 cycles into BUSY; REQ_DONE=01, ERR=1, REQ_DEC=0.
